register_writeback_unit: RTL

- Register-file write-back stage for the core: selects the write-back value from memory read data, ALU result or PC, and drives a registered register-file write port.
- For UART-input instructions it stalls the PC and collects one byte or a full little-endian word from the receive stream over a valid/ready handshake.
- Supports an optional receive timeout that writes all-ones (EOF).
- Sits between the MEM stage and the register file; successor to the single-word, combinational write-back selector.

---
 rtl/register_writeback_unit.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/register_writeback_unit.sv
`default_nettype none
// ============================================================================
//  Module   : register_writeback_unit
//  Purpose  : Register-file write-back stage. Selects memory data, ALU result
//             or PC for a registered write port, and for UART-input
//             instructions stalls the PC while a byte or a little-endian word
//             is collected from the receive stream (optional EOF timeout).
//  Revision : 1.0 - initial release
// ============================================================================
module register_writeback_unit #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 5,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_to_reg,
  input  logic              uart_to_reg,
  input  logic              in_word,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] read_data,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] pc,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              reg_write,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_data,
  output logic              pc_enable,
  output logic              rx_timeout
);

  localparam int NB = DATA_W / 8;
  localparam int CW = $clog2(NB + 1);
  // Timer width collapses to one unused bit when the timeout is disabled.
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_COLLECT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              word_q, word_d;
  logic [ADDR_W-1:0] addr_lat_q, addr_lat_d;
  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0] reg_data_q, reg_data_d;
  logic              rx_timeout_q, rx_timeout_d;

  logic [DATA_W-1:0] asm_w;
  logic [CW-1:0]     target_w;
  logic              pc_en_w;

  // Assembly buffer with the incoming byte dropped into lane count_q.
  always_comb begin
    asm_w = buf_q;
    for (int i = 0; i < NB; i++) begin
      if (count_q == CW'(i)) begin
        asm_w[8*i +: 8] = in_data;
      end
    end
    target_w = word_q ? CW'(NB) : CW'(1);
  end

  // Next-state, write-port and PC-stall decisions.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    timer_d      = timer_q;
    buf_d        = buf_q;
    word_d       = word_q;
    addr_lat_d   = addr_lat_q;
    reg_write_d  = 1'b0;
    reg_addr_d   = reg_addr_q;
    reg_data_d   = reg_data_q;
    rx_timeout_d = 1'b0;
    pc_en_w      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (uart_to_reg) begin
          // Stall the PC and start a fresh collection; mem_to_reg is ignored.
          addr_lat_d = rd_addr;
          word_d     = in_word;
          buf_d      = '0;
          count_d    = '0;
          timer_d    = '0;
          state_d    = S_COLLECT;
        end else begin
          pc_en_w     = 1'b1;
          reg_write_d = (mem_to_reg != 2'b00);
          reg_addr_d  = rd_addr;
          case (mem_to_reg)
            2'b01:   reg_data_d = read_data;
            2'b10:   reg_data_d = alu_result;
            2'b11:   reg_data_d = pc;
            default: reg_data_d = reg_data_q;
          endcase
        end
      end

      S_COLLECT: begin
        if (in_valid) begin
          // An accepted byte always wins over a timer expiring this cycle.
          if ((count_q + CW'(1)) == target_w) begin
            pc_en_w     = 1'b1;
            reg_write_d = 1'b1;
            reg_addr_d  = addr_lat_q;
            reg_data_d  = asm_w;
            state_d     = S_IDLE;
          end else begin
            buf_d   = asm_w;
            count_d = count_q + CW'(1);
          end
          timer_d = '0;
        end else if ((TIMEOUT_CYCLES > 0) && (timer_q == TW'(TIMEOUT_CYCLES - 1))) begin
          // Receive stream went silent: deliver EOF, drop partial bytes.
          pc_en_w      = 1'b1;
          reg_write_d  = 1'b1;
          reg_addr_d   = addr_lat_q;
          reg_data_d   = '1;
          rx_timeout_d = 1'b1;
          state_d      = S_IDLE;
        end else if (TIMEOUT_CYCLES > 0) begin
          timer_d = timer_q + TW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and registered write-port flops, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      timer_q      <= '0;
      buf_q        <= '0;
      word_q       <= 1'b0;
      addr_lat_q   <= '0;
      reg_write_q  <= 1'b0;
      reg_addr_q   <= '0;
      reg_data_q   <= '0;
      rx_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      timer_q      <= timer_d;
      buf_q        <= buf_d;
      word_q       <= word_d;
      addr_lat_q   <= addr_lat_d;
      reg_write_q  <= reg_write_d;
      reg_addr_q   <= reg_addr_d;
      reg_data_q   <= reg_data_d;
      rx_timeout_q <= rx_timeout_d;
    end
  end

  assign in_ready   = (state_q == S_COLLECT);
  assign pc_enable  = pc_en_w & ~reset;
  assign reg_write  = reg_write_q;
  assign reg_addr   = reg_addr_q;
  assign reg_data   = reg_data_q;
  assign rx_timeout = rx_timeout_q;

endmodule
`default_nettype wire
